// File: rtl/seg7_pkg.sv
// Shared definitions for the BCD converter and seven-segment scan driver.
package seg7_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic int unsigned MAX_VAL(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int i = 0; i < int'(digits); i++) v = v * 10;
        return v - 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: digits of 5 or more get +3 ahead of the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per clock.
// Optional BIN2BCD_BLANK_EN: leading-zero digits are emitted as the blank code.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [2:0]            ndigits,
    output logic                  ovf
);

    localparam int          SW   = 4*DIGITS + 1;
    localparam int          CW   = $clog2(IN_W + 1);
    localparam logic [31:0] MAXV = 32'(MAX_VAL(DIGITS));

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IN_W-1:0]     shreg_q, shreg_d;
    logic [IN_W-1:0]     lat_q, lat_d;
    logic [SW-1:0]       scr_q, scr_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [2:0]          ndigits_q, ndigits_d;
    logic                ovf_q, ovf_d;

    logic [4*(DIGITS+1)-1:0] adj;
    logic [SW-1:0]           scr_shift;
    logic [4*DIGITS-1:0]     res_bcd;
    logic [2:0]              res_nd;
    logic                    res_ovf;
    logic                    unused_adj;

    // Top corrector only sees the overflow bit; its output never feeds the shift.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
        if (g < DIGITS) begin : g_dig
            bcd_add3 u_add3 (.din(scr_q[4*g +: 4]), .dout(adj[4*g +: 4]));
        end else begin : g_top
            bcd_add3 u_add3 (.din({3'b000, scr_q[SW-1]}), .dout(adj[4*g +: 4]));
        end
    end

    assign scr_shift  = {adj[4*DIGITS-1:0], shreg_q[IN_W-1]};
    assign unused_adj = ^adj[4*(DIGITS+1)-1:4*DIGITS];
    assign res_ovf    = 32'(lat_q) > MAXV;

    // Final result is formed from the last shift so it lands with the DONE cycle.
    always_comb begin
        res_nd  = 3'd1;
        res_bcd = scr_shift[4*DIGITS-1:0];
        for (int i = 1; i < DIGITS; i++) begin
            if (scr_shift[4*i +: 4] != 4'd0) res_nd = 3'(i + 1);
        end
`ifdef BIN2BCD_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            if (i >= int'(res_nd)) res_bcd[4*i +: 4] = BCD_BLANK;
        end
`endif
        if (res_ovf) begin
            res_bcd = {DIGITS{4'h9}};
            res_nd  = 3'(DIGITS);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        lat_d     = lat_q;
        scr_d     = scr_q;
        bcd_d     = bcd_q;
        ndigits_d = ndigits_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    shreg_d = bin;
                    lat_d   = bin;
                    scr_d   = '0;
                    cnt_d   = CW'(IN_W);
                end
            end
            SHIFT: begin
                scr_d   = scr_shift;
                shreg_d = {shreg_q[IN_W-2:0], 1'b0};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d   = DONE;
                    bcd_d     = res_bcd;
                    ndigits_d = res_nd;
                    ovf_d     = res_ovf;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            lat_q     <= '0;
            scr_q     <= '0;
            bcd_q     <= '0;
            ndigits_q <= 3'd1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            lat_q     <= lat_d;
            scr_q     <= scr_d;
            bcd_q     <= bcd_d;
            ndigits_q <= ndigits_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign bcd     = bcd_q;
    assign ndigits = ndigits_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against an arithmetic decimal model.
module tb_bin2bcd_seq;

    localparam int IN_W   = 14;
    localparam int DIGITS = 4;
    localparam int BW     = 4*DIGITS;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [IN_W-1:0] bin;
    logic            busy, done, ovf;
    logic [BW-1:0]   bcd;
    logic [2:0]      ndigits;

    int  n_chk    = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    time last_t   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .ndigits(ndigits), .ovf(ovf)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lim();
        return 10**DIGITS - 1;
    endfunction

    function automatic int ref_nd(input int v);
        int n, t;
        if (v > lim()) return DIGITS;
        n = 1;
        t = v / 10;
        while (t > 0) begin
            n++;
            t = t / 10;
        end
        return n;
    endfunction

    function automatic logic [BW-1:0] ref_bcd(input int v);
        logic [BW-1:0] r;
        int nd;
        nd = ref_nd(v);
        r  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v > lim()) r[4*i +: 4] = 4'd9;
            else           r[4*i +: 4] = 4'((v / (10**i)) % 10);
`ifdef BIN2BCD_BLANK_EN
            if (v <= lim() && i >= nd) r[4*i +: 4] = 4'hF;
`endif
        end
        return r;
    endfunction

    task automatic check_result(input int v, input string tag);
        chk({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
        chk({tag, "_nd"},  32'(ndigits), 32'(ref_nd(v)));
        chk({tag, "_ovf"}, 32'(ovf), (v > lim()) ? 32'd1 : 32'd0);
    endtask

    // Called #1 after a posedge while the DUT is idle; returns in the first IDLE cycle after DONE.
    task automatic convert(input int v, input string tag);
        int n;
        n     = 0;
        start = 1'b1;
        bin   = IN_W'(v);
        @(posedge clk); #1;
        start = 1'b0;
        bin   = IN_W'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(IN_W));
        last_t = $time;
        check_result(v, tag);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"},  32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_bcd"},  32'(bcd), 32'd0);
        chk({tag, "_nd"},   32'(ndigits), 32'd1);
        chk({tag, "_ovf"},  32'(ovf), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0;
        time t_prev;

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        convert(0,     "zero");
        convert(255,   "v255");
        convert(9999,  "v9999");
        convert(12345, "v12345");
        convert(42,    "v42");
        convert(10000, "v10000");
        convert(16383, "vmax");

        // Extra starts during SHIFT and DONE must be ignored.
        c0    = done_cnt;
        start = 1'b1;
        bin   = IN_W'(100);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= IN_W; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                start = 1'b1;
                bin   = IN_W'(7);
            end
            if (k == 3) start = 1'b0;
        end
        chk("rp_done", 32'(done), 32'd1);
        check_result(100, "rp");
        start = 1'b1;
        bin   = IN_W'(7);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rp_count", 32'(done_cnt - c0), 32'd1);
        chk("rp_bcd_hold", 32'(bcd), 32'(ref_bcd(100)));

        // Asynchronous reset mid-conversion aborts with no done pulse.
        c0    = done_cnt;
        start = 1'b1;
        bin   = IN_W'(9000);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_nodone", 32'(done_cnt - c0), 32'd0);
        convert(58, "v58");

        // Back-to-back conversions, each start in the first IDLE cycle.
        convert(1, "b1");
        t_prev = last_t;
        convert(10, "b10");
        chk("gap1", 32'((last_t - t_prev) / 10), 32'd16);
        t_prev = last_t;
        convert(100, "b100");
        chk("gap2", 32'((last_t - t_prev) / 10), 32'd16);
        t_prev = last_t;
        convert(1000, "b1000");
        chk("gap3", 32'((last_t - t_prev) / 10), 32'd16);

        for (int i = 0; i < 40; i++) begin
            int v;
            if (i % 4 == 0) v = 9990 + int'($urandom_range(0, 20));
            else            v = int'($urandom_range(0, 2**IN_W - 1));
            convert(v, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
